uart_tx: RTL and testbench

Serial UART transmitter that converts a parallel byte into an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity bit, and stop bit. It is the transmit half of the UART, paired with the receive shift register. It generates its own bit timing from `clk` and hands bytes in through a single-cycle start handshake.

---
 rtl/uart_pkg.sv | 16 +
 rtl/tx_piso.sv | 31 +++
 rtl/uart_tx.sv | 160 ++++++++++++++++
 tb/tb_uart_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE   = 3'd0,
    UART_START  = 3'd1,
    UART_DATA   = 3'd2,
    UART_PARITY = 3'd3,
    UART_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_START_LVL = 1'b0;
  localparam logic        UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/tx_piso.sv
// Parallel-in serial-out shift register; shifts right so data leaves LSB first.
module tx_piso
  import uart_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_i,
  input  logic                      shift_i,
  input  logic [UART_DATA_BITS-1:0] data_i,
  output logic                      serial_o,
  output logic                      next_o
);

  logic [UART_DATA_BITS-1:0] sr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= {1'b0, sr_q[UART_DATA_BITS-1:1]};
    end
  end

  // next_o is the bit that becomes serial_o after a shift, so the top can
  // register the line level in the same edge as the shift.
  assign serial_o = sr_q[0];
  assign next_o   = sr_q[1];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN to compile in the parity bit (PARITY_ODD selects odd).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_datain,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'(UART_IDLE);
  localparam logic [2:0] S_START  = 3'(UART_START);
  localparam logic [2:0] S_DATA   = 3'(UART_DATA);
  localparam logic [2:0] S_STOP   = 3'(UART_STOP);
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'(UART_PARITY);
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             piso_load, piso_shift;
  logic             piso_bit0, piso_bit1;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`else
  logic             unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  tx_piso u_piso (
    .clk      (clk),
    .reset    (reset),
    .load_i   (piso_load),
    .shift_i  (piso_shift),
    .data_i   (tx_datain),
    .serial_o (piso_bit0),
    .next_o   (piso_bit1)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  // Line level is derived from the next state so it changes on the same edge as the FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    done_d     = 1'b0;
    serial_d   = UART_STOP_LVL;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d   = S_START;
          piso_load = 1'b1;
          cnt_d     = '0;
          idx_d     = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = (^tx_datain) ^ PARITY_ODD;
`endif
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            piso_shift = 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START:  serial_d = UART_START_LVL;
      S_DATA:   serial_d = piso_shift ? piso_bit1 : piso_bit0;
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_d = parity_q;
`endif
      default:  serial_d = UART_STOP_LVL;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      serial_q <= UART_STOP_LVL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: even and odd parity instances share all inputs.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_datain;
  logic       ser_ev, busy_ev, done_ev;
  logic       ser_od, busy_od, done_od;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) u_dut_ev (
    .clk       (clk),
    .reset     (reset),
    .tx_start  (tx_start),
    .tx_datain (tx_datain),
    .tx_serial (ser_ev),
    .tx_busy   (busy_ev),
    .tx_done   (done_ev)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) u_dut_od (
    .clk       (clk),
    .reset     (reset),
    .tx_start  (tx_start),
    .tx_datain (tx_datain),
    .tx_serial (ser_od),
    .tx_busy   (busy_od),
    .tx_done   (done_od)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " ser_ev"}, ser_ev, 1'b1);
    check({tag, " ser_od"}, ser_od, 1'b1);
    check({tag, " busy"}, busy_ev, 1'b0);
    check({tag, " done_ev"}, done_ev, 1'b0);
    check({tag, " done_od"}, done_od, 1'b0);
  endtask

  task automatic idle_for(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check_idle(tag);
      @(negedge clk);
    end
  endtask

  // Request a frame; returns at the first sample of the start bit.
  task automatic kick(input logic [7:0] d);
    tx_start  = 1'b1;
    tx_datain = d;
    @(negedge clk);
    tx_start  = 1'b0;
  endtask

  // Checks a full frame; pe/po are the hand-computed even/odd parity bits.
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic po,
                           input bit chain, input logic [7:0] nd, input int poke);
    logic [10:0] fe, fo;
`ifdef UART_TX_PARITY_EN
    fe = {1'b1, pe, d, 1'b0};
    fo = {1'b1, po, d, 1'b0};
`else
    fe = {1'b0, 1'b1, d, 1'b0};
    fo = {1'b0, 1'b1, d, 1'b0};
`endif
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < CPB; c++) begin
        check($sformatf("%02h ser_ev b%0d", d, b), ser_ev, fe[b]);
        check($sformatf("%02h ser_od b%0d", d, b), ser_od, fo[b]);
        check($sformatf("%02h busy b%0d", d, b), busy_ev, 1'b1);
        check($sformatf("%02h done b%0d", d, b), done_ev, 1'b0);
        if (b * CPB + c == poke) begin
          tx_start  = 1'b1;
          tx_datain = 8'h00;
        end else if (b * CPB + c == poke + 1) begin
          tx_start  = 1'b0;
        end
        @(negedge clk);
      end
    end
    check($sformatf("%02h done_ev end", d), done_ev, 1'b1);
    check($sformatf("%02h done_od end", d), done_od, 1'b1);
    check($sformatf("%02h busy end", d), busy_ev, 1'b0);
    check($sformatf("%02h ser end", d), ser_ev, 1'b1);
    if (chain) begin
      tx_start  = 1'b1;
      tx_datain = nd;
    end
    @(negedge clk);
    tx_start = 1'b0;
    if (!chain) check($sformatf("%02h done clr", d), done_ev, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    tx_start  = 1'b0;
    tx_datain = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    idle_for(100, "idle");

    kick(8'hA5);
    run_frame(8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, -1);
    idle_for(5, "gap1");

    kick(8'h07);
    run_frame(8'h07, 1'b1, 1'b0, 1'b0, 8'h00, -1);
    idle_for(5, "gap2");

    // Second start lands in the done cycle; its start bit must follow immediately.
    kick(8'h3C);
    run_frame(8'h3C, 1'b0, 1'b1, 1'b1, 8'hFF, -1);
    run_frame(8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, -1);
    idle_for(5, "gap3");

    kick(8'h55);
    run_frame(8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 12);
    idle_for(30, "after busy");

    kick(8'h81);
    repeat (3 * CPB + 1) @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle("abort");
    repeat (3) begin
      @(negedge clk);
      check_idle("abort hold");
    end
    reset = 1'b0;
    @(negedge clk);
    idle_for(5, "post abort");

    kick(8'h81);
    run_frame(8'h81, 1'b0, 1'b1, 1'b0, 8'h00, -1);
    idle_for(10, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
